lane_serial_divider: RTL

LANE_SERIAL_DIVIDER -- requirements
Module: lane_serial_divider

---
 rtl/lane_serial_divider.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lane_serial_divider.sv
// Radix-2 restoring serial divider (DIVU/DIV/REMU/REM) with valid/ready handshakes and flush.
// Define LANE_SERDIV_EARLY_TERM_EN to skip the dividend's leading zeros and shorten DIVIDE.
module lane_serial_divider #(
  parameter int WIDTH   = 64,
  parameter int IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IdWidth-1:0] id_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  input  logic [1:0]         opcode_i,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic               flush_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [IdWidth-1:0] id_o,
  output logic [WIDTH-1:0]   res_o
);

  localparam int CntWidth = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    dividend_q, dividend_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic                negQuot_q, negQuot_d;
  logic                negRem_q, negRem_d;
  logic                isRem_q, isRem_d;
  logic                divZero_q, divZero_d;
  logic [IdWidth-1:0]  id_q, id_d;

  logic                aNeg, bNeg;
  logic [WIDTH-1:0]    aMag, bMag;
  logic [CntWidth-1:0] startCnt;
  logic [WIDTH-1:0]    startDividend;
  logic [WIDTH:0]      remShift;
  logic                stepGe;
  logic [WIDTH-1:0]    stepDiff;
  logic [WIDTH-1:0]    quotFix, remFix;

`ifdef LANE_SERDIV_EARLY_TERM_EN
  logic [CntWidth-1:0] lzcVal;

  function automatic logic [CntWidth-1:0] countLeadingZeros(input logic [WIDTH-1:0] v);
    logic [CntWidth-1:0] n;
    logic                found;
    n     = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + CntWidth'(1);
      end
    end
    return n;
  endfunction
`endif

  // Signed requests are divided as magnitudes; the signs are reapplied when the result is read out.
  always_comb begin
    aNeg = opcode_i[0] & op_a_i[WIDTH-1];
    bNeg = opcode_i[0] & op_b_i[WIDTH-1];
    aMag = aNeg ? -op_a_i : op_a_i;
    bMag = bNeg ? -op_b_i : op_b_i;
`ifdef LANE_SERDIV_EARLY_TERM_EN
    lzcVal        = countLeadingZeros(aMag);
    startCnt      = (lzcVal == CntWidth'(WIDTH)) ? CntWidth'(1) : CntWidth'(WIDTH) - lzcVal;
    startDividend = aMag << lzcVal;
`else
    startCnt      = CntWidth'(WIDTH);
    startDividend = aMag;
`endif
  end

  // The dividend register shifts out its top bit each step while quotient bits fill it from below.
  always_comb begin
    remShift = {rem_q, dividend_q[WIDTH-1]};
    stepGe   = remShift >= {1'b0, divisor_q};
    stepDiff = remShift[WIDTH-1:0] - divisor_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    negQuot_d  = negQuot_q;
    negRem_d   = negRem_q;
    isRem_d    = isRem_q;
    divZero_d  = divZero_q;
    id_d       = id_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_vld_i) begin
            state_d    = DIVIDE;
            cnt_d      = startCnt;
            dividend_d = startDividend;
            rem_d      = '0;
            divisor_d  = bMag;
            negQuot_d  = aNeg ^ bNeg;
            negRem_d   = aNeg;
            isRem_d    = opcode_i[1];
            divZero_d  = (op_b_i == '0);
            id_d       = id_i;
          end
        end
        DIVIDE: begin
          dividend_d = {dividend_q[WIDTH-2:0], stepGe};
          rem_d      = stepGe ? stepDiff : remShift[WIDTH-1:0];
          cnt_d      = cnt_q - CntWidth'(1);
          if (cnt_q == CntWidth'(1)) state_d = FINISH;
        end
        FINISH: begin
          if (out_rdy_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
      isRem_q    <= 1'b0;
      divZero_q  <= 1'b0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
      isRem_q    <= isRem_d;
      divZero_q  <= divZero_d;
      id_q       <= id_d;
    end
  end

  // Divide by zero forces an all-ones quotient; min / -1 falls out naturally from magnitude arithmetic.
  always_comb begin
    quotFix = divZero_q ? '1 : (negQuot_q ? -dividend_q : dividend_q);
    remFix  = negRem_q ? -rem_q : rem_q;
    res_o   = (state_q == FINISH) ? (isRem_q ? remFix : quotFix) : '0;
  end

  assign in_rdy_o  = (state_q == IDLE);
  assign out_vld_o = (state_q == FINISH);
  assign id_o      = id_q;

endmodule
